// File: rtl/tdm_mux8.sv
// tdm_mux8: round-robin 8-to-1 time-division multiplexer with channel index, valid and start-of-frame strobes.
// Build option TDM_MUX8_SAMPLE_LATCH_EN: capture the lane once per slot and hold it on Out.
module tdm_mux8 #(
  parameter int unsigned DWELL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic [7:0] In,
  input  logic [7:0] Mask,
  output logic       Out,
  output logic [2:0] Sel,
  output logic       Valid,
  output logic       SOF
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [7:0] cnt_q, cnt_d;
  logic       frame_q, frame_d;
  logic       out_q, out_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic [2:0] first_ch, next_ch;

  // Descending scans so the last hit wins: lowest set bit, and nearest set bit above ch
  // (offset 8 wraps to ch itself, covering the single-channel case).
  always_comb begin
    first_ch = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (Mask[3'(i - 1)]) first_ch = 3'(i - 1);
    end
    next_ch = ch_q;
    for (int unsigned i = 8; i > 0; i--) begin
      if (Mask[3'(ch_q + 3'(i))]) next_ch = 3'(ch_q + 3'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (E && (Mask != '0)) begin
          state_d = SCAN;
          ch_d    = first_ch;
          cnt_d   = '0;
          frame_d = 1'b1;
        end
      end
      SCAN: begin
        if (!E || (Mask == '0)) begin
          state_d = IDLE;
          ch_d    = '0;
          cnt_d   = '0;
          frame_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          ch_d    = next_ch;
          cnt_d   = '0;
          frame_d = (next_ch <= ch_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_q == SCAN);
    sel_d   = ch_q;
    sof_d   = (state_q == SCAN) && (cnt_q == '0) && frame_q;
`ifdef TDM_MUX8_SAMPLE_LATCH_EN
    out_d = out_q;
    if (state_q != SCAN)  out_d = 1'b0;
    else if (cnt_q == '0) out_d = In[ch_q];
`else
    out_d = (state_q == SCAN) && In[ch_q];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      out_q   <= 1'b0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
    end
  end

  assign Out   = out_q;
  assign Sel   = sel_q;
  assign Valid = valid_q;
  assign SOF   = sof_q;

endmodule

// File: tb/tb_tdm_mux8.sv
// Self-checking bench for tdm_mux8: per-cycle scoreboard against a behavioural model plus directed timing checks.
module tb_tdm_mux8;
  localparam int DW = 10;

  logic       clk = 1'b0;
  logic       rst, E;
  logic [7:0] In, Mask;
  logic       Out;
  logic [2:0] Sel;
  logic       Valid, SOF;

  tdm_mux8 #(.DWELL(DW)) dut (
    .clk(clk), .rst(rst), .E(E), .In(In), .Mask(Mask),
    .Out(Out), .Sel(Sel), .Valid(Valid), .SOF(SOF)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       o;
    logic [2:0] s;
    logic       v;
    logic       f;
  } obs_t;

  obs_t sb[$];
  int   tests = 0, fails = 0;

  bit m_scan = 0, m_fs = 0, m_lat = 0;
  int m_ch = 0, m_cnt = 0;

  int cycle = 0, last_sof = -1, sof_period = 0;
  int run = 0, last_run = 0;
  bit p_valid = 0;
  logic [2:0] p_sel = '0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: predict outputs for the coming edge, advance the model, then compare.
  task automatic drive_cycle();
    obs_t e, got;
    int   nxt, low;
    e = '0;
    if (rst) begin
      m_scan = 0; m_ch = 0; m_cnt = 0; m_fs = 0; m_lat = 0;
    end else begin
      e.v = m_scan;
      e.s = m_ch[2:0];
      e.f = m_scan && (m_cnt == 0) && m_fs;
`ifdef TDM_MUX8_SAMPLE_LATCH_EN
      if (m_scan && m_cnt == 0) m_lat = In[m_ch];
      e.o = m_scan && m_lat;
`else
      e.o = m_scan && In[m_ch];
`endif
      if (!m_scan) begin
        if (E && Mask != 0) begin
          low = 0;
          for (int i = 7; i >= 0; i--) if (Mask[i]) low = i;
          m_scan = 1; m_ch = low; m_cnt = 0; m_fs = 1;
        end
      end else if (!E || Mask == 0) begin
        m_scan = 0; m_ch = 0; m_cnt = 0; m_fs = 0;
      end else if (m_cnt == DW - 1) begin
        nxt = (m_ch + 1) % 8;
        while (!Mask[nxt]) nxt = (nxt + 1) % 8;
        m_fs  = (nxt <= m_ch);
        m_ch  = nxt;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {Out, Sel, Valid, SOF};
    e = sb.pop_front();
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL scoreboard cycle %0d: got o=%b s=%0d v=%b f=%b expected o=%b s=%0d v=%b f=%b",
             cycle, got.o, got.s, got.v, got.f, e.o, e.s, e.v, e.f);
    end
    cycle++;
    if (!Valid) last_sof = -1;
    else if (SOF) begin
      if (last_sof >= 0) sof_period = cycle - last_sof;
      last_sof = cycle;
    end
    if (Valid && p_valid && Sel == p_sel) run++;
    else begin
      if (p_valid) last_run = run;
      run = 1;
    end
    p_sel = Sel;
    p_valid = Valid;
  endtask

  initial begin
    int n, changes;
    logic prev;

    // Reset held with everything enabled
    rst = 1; E = 1; Mask = 8'hFF; In = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      check("reset_outputs", int'({Out, Sel, Valid, SOF}), 0);
    end
    rst = 0;
    drive_cycle();
    check("valid_one_edge_after_rst", int'(Valid), 0);
    drive_cycle();
    check("valid_two_edges_after_rst", int'(Valid), 1);
    check("first_sel", int'(Sel), 0);
    check("first_sof", int'(SOF), 1);

    // Full scan
    In = 8'b1010_0101;
    for (int i = 0; i < 170; i++) drive_cycle();
    check("full_sof_period", sof_period, 80);
    check("full_slot_len", last_run, 10);

    // Sparse mask
    Mask = 8'b1000_0010; sof_period = 0;
    for (int i = 0; i < 80; i++) drive_cycle();
    check("sparse_sof_period", sof_period, 20);
    check("sparse_slot_len", last_run, 10);
    check("sparse_sel_legal", int'(Sel == 3'd1 || Sel == 3'd7), 1);

    // Single channel
    Mask = 8'h08; sof_period = 0;
    for (int i = 0; i < 40; i++) drive_cycle();
    check("single_sel", int'(Sel), 3);
    check("single_sof_period", sof_period, 10);

    // Mid-slot mask change: Sel=3 slot must finish first
    n = 0;
    while (!(m_scan && m_ch == 3 && m_cnt == 4) && n < 50) begin drive_cycle(); n++; end
    check("reach_ch3_cnt4", int'(n < 50), 1);
    Mask = 8'h10;
    for (int i = 0; i < 6; i++) begin
      drive_cycle();
      check("slot3_completes", int'(Sel), 3);
    end
    drive_cycle();
    check("then_sel4", int'(Sel), 4);

    // Drop E at ch=4, cnt=5
    n = 0;
    while (!(m_scan && m_ch == 4 && m_cnt == 5) && n < 50) begin drive_cycle(); n++; end
    check("reach_ch4_cnt5", int'(n < 50), 1);
    E = 0;
    drive_cycle();
    check("valid_at_edge_j", int'(Valid), 1);
    drive_cycle();
    check("valid_after_drop", int'(Valid), 0);
    check("out_after_drop", int'(Out), 0);
    check("sel_after_drop", int'(Sel), 0);

    // Re-enable restarts at the lowest set bit with SOF
    Mask = 8'hFF; E = 1;
    drive_cycle();
    drive_cycle();
    check("restart_valid", int'(Valid), 1);
    check("restart_sel", int'(Sel), 0);
    check("restart_sof", int'(SOF), 1);

    // Reset mid-slot
    for (int i = 0; i < 13; i++) drive_cycle();
    rst = 1;
    drive_cycle();
    check("rst_mid_slot", int'({Out, Sel, Valid, SOF}), 0);
    rst = 0;

    // Lane toggling within the Sel=2 slot
    In = 8'b0000_0100;
    n = 0;
    while (!(m_scan && m_ch == 2 && m_cnt == 0) && n < 100) begin drive_cycle(); n++; end
    check("reach_ch2_start", int'(n < 100), 1);
    changes = 0;
    prev = 1'b0;
    for (int k = 0; k < DW; k++) begin
      drive_cycle();
      if (k == 0) check("lane2_first_sample", int'(Out), 1);
      else if (Out != prev) changes++;
      prev = Out;
      In[2] = ~In[2];
    end
`ifdef TDM_MUX8_SAMPLE_LATCH_EN
    check("lane2_out_changes", changes, 0);
`else
    check("lane2_out_changes", changes, DW - 1);
`endif
    for (int i = 0; i < 5; i++) drive_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tdm_mux8.md
# tdm_mux8

Time-division 8-to-1 multiplexer: the transmit end of the 1-to-8 demultiplexer path. It scans eight input lanes round-robin, holds each active lane for a programmable dwell, and drives the selected bit onto one serial line. A 3-bit channel index travels alongside, so a downstream Demux1to8 can steer each bit back to its lane. Start-of-frame and valid strobes let the receiver align.

## Interface
- DWELL, 10: cycles spent on each channel slot; legal range 1..255, held in an 8-bit counter.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- E  in  1  scan enable.
- In  in  8  input lanes; bit i is channel i.
- Mask  in  8  channel include mask; 1 includes the channel in the scan.
- Out  out  1  registered sample of the current lane.
- Sel  out  3  channel index that Out belongs to.
- Valid  out  1  Out and Sel carry scan data.
- SOF  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- Internal state:
  - FSM with states IDLE and SCAN.
  - Channel pointer `ch` (3 bits).
  - Dwell counter `cnt` (8 bits).
- Reset values:
  - state = IDLE, ch = 0, cnt = 0.
  - Out = 0, Sel = 0, Valid = 0, SOF = 0.
- IDLE -> SCAN when E = 1 and Mask != 0 are sampled. On that transition:
  - ch is loaded with the lowest set bit of Mask.
  - cnt = 0.
  - The slot is marked as the frame start.
- SCAN, each cycle:
  - cnt increments.
  - When cnt = DWELL-1, cnt returns to 0 and ch advances to the next set bit of Mask.
  - The search runs upward from ch+1 and wraps modulo 8.
  - If ch is the only set bit, ch is reloaded with itself and a new slot begins.
- Frame start: a slot is a frame start when it is entered from IDLE, or when the new ch is less than or equal to the old ch (wrap).
- SCAN -> IDLE on the next edge when E = 0 or Mask = 0 is sampled. ch and cnt return to 0.
- Mask changes during SCAN:
  - Take effect only at the next slot boundary.
  - The current slot always completes its dwell, even if its own mask bit has cleared.
- Output register stage, updated every cycle:
  - Valid <= (state == SCAN).
  - Sel <= ch.
  - SOF <= (state == SCAN) and (cnt == 0) and (slot is a frame start).
  - Out <= In[ch] when in SCAN, else 0.
- rst has priority over E, Mask and every other condition.

## Timing
- Start-up:
  - E rises and is sampled at edge k; state = SCAN at edge k.
  - Valid, Sel, SOF and the first Out appear at edge k+1.
- Latency: Out, Sel, Valid and SOF are mutually aligned and lag the internal ch/cnt by exactly one cycle.
- Slot length: exactly DWELL cycles. DWELL = 1 advances the channel every cycle.
- Frame length: DWELL × popcount(Mask) cycles. SOF period equals the frame length.
- Shut-down:
  - E = 0 sampled at edge j puts the FSM in IDLE at edge j.
  - Valid = 0 and Out = 0 at edge j+1.
  - Sel holds 0 from edge j+1 onward.
- Re-enable always restarts at the lowest set Mask bit, with SOF.
- rst asserted mid-slot: all outputs take their reset values at that edge; no partial slot resumes.

## Configuration
- Macro: TDM_MUX8_SAMPLE_LATCH_EN.
- Defined: In[ch] is captured once, on the first cycle of each slot (cnt == 0), and Out holds that value for the whole slot. This makes Out glitch-free against lane toggles mid-slot.
- Undefined: Out re-samples In[ch] every cycle, so lane activity within a slot is passed through with one-cycle latency.
- Control timing and all other outputs are identical in both builds.

## Test plan
- Reset:
  - Stimulus: rst = 1 for 3 cycles with E = 1, Mask = 8'hFF, In = 8'hFF.
  - Required: Out = 0, Sel = 0, Valid = 0, SOF = 0 on every cycle.
  - Then rst = 0: Valid rises exactly 2 edges after rst falls.
- Full scan:
  - Stimulus: DWELL = 10, Mask = 8'hFF, In = 8'b1010_0101 constant.
  - Required: Sel steps 0..7, each value held 10 cycles, and Out = In[Sel].
  - Required: SOF pulses on Sel = 0 every 80 cycles.
- Sparse mask:
  - Stimulus: Mask = 8'b1000_0010.
  - Required: Sel runs 1,7,1,7 with 10 cycles each; SOF pulses on each entry to Sel = 1, every 20 cycles.
- Single channel and mid-slot mask change:
  - Stimulus: Mask = 8'h08.
  - Required: Sel = 3 continuously and SOF every 10 cycles.
  - Stimulus: switch Mask to 8'h10 mid-slot.
  - Required: the Sel = 3 slot completes its 10 cycles, then Sel = 4.
- E drop and rst mid-slot:
  - Stimulus: drop E at Sel = 4, cnt = 5.
  - Required: one cycle later Valid = 0 and Out = 0.
  - Stimulus: re-enable with Mask = 8'hFF.
  - Required: restart at Sel = 0 with SOF.
  - Stimulus: assert rst mid-slot.
  - Required: all outputs are 0 at the next edge.
- Latch option:
  - Stimulus: Sel = 2 slot, In[2] toggling every cycle.
  - Required with TDM_MUX8_SAMPLE_LATCH_EN: Out is constant for the whole slot, equal to In[2] at slot start.
  - Required without it: Out follows In[2] with 1-cycle lag.
